// File: rtl/tdm_demux8.sv
// tdm_demux8: rebuilds an 8-bit word from a time-division serial stream.
// A 3-bit slot counter selects which staging bit captures D on each accepted
// cycle; a completed frame is moved to Q with a one-cycle Valid pulse.
module tdm_demux8 #(
    parameter bit FREE_RUN = 1'b1
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       En,
    input  logic       Sync,
    input  logic       D,
    output logic [7:0] Q,
    output logic       Valid,
    output logic [2:0] Slot,
    output logic [7:0] Y,
    output logic       Err
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e     state_q, state_d;
    logic [2:0] slot_q, slot_d;
    logic [7:0] staging_q, staging_d;
    logic [7:0] q_q, q_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;

    // Next-state: frame capture, completion, and Sync realignment.
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        staging_d = staging_q;
        q_d       = q_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        if (En) begin
            unique case (state_q)
                StIdle: begin
                    if (Sync) begin
                        staging_d[0] = D;
                        slot_d       = 3'd1;
                        state_d      = StRun;
                    end
                end
                StRun: begin
                    if (Sync) begin
                        // Sync anywhere but slot 0 abandons the partial frame.
                        err_d        = (slot_q != 3'd0);
                        staging_d[0] = D;
                        slot_d       = 3'd1;
                    end else begin
                        staging_d[slot_q] = D;
                        slot_d            = slot_q + 3'd1;
                        if (slot_q == 3'd7) begin
                            // Bit 7 goes straight into Q; staging is not cleared.
                            q_d     = {D, staging_q[6:0]};
                            valid_d = 1'b1;
                            if (!FREE_RUN) begin
                                state_d = StIdle;
                            end
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= StIdle;
            slot_q    <= 3'd0;
            staging_q <= 8'h00;
            q_q       <= 8'h00;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            staging_q <= staging_d;
            q_q       <= q_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    // Slot decode: one-hot while running, silent when idle.
    always_comb begin
        Y = 8'h00;
        if (state_q == StRun) begin
            Y[slot_q] = 1'b1;
        end
    end

    assign Q     = q_q;
    assign Valid = valid_q;
    assign Slot  = slot_q;
    assign Err   = err_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// tb_tdm_demux8: drives a free-running and a framed instance with the same
// stream; a reference model predicts per-cycle outputs and completed frames.
module tb_tdm_demux8;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       En = 1'b0;
    logic       Sync = 1'b0;
    logic       D = 1'b0;

    logic [7:0] q0, q1, y0, y1;
    logic [2:0] slot0, slot1;
    logic       valid0, valid1, err0, err1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0] slot;
        logic [7:0] y;
        logic       err;
        logic       valid;
        logic [7:0] q;
    } exp_t;

    exp_t       cyc0[$], cyc1[$];
    logic [7:0] frm0[$], frm1[$];

    // Model: pos = bits gathered in current frame, -1 when waiting for Sync.
    int         pos[2];
    logic [7:0] bits[2];
    logic [7:0] qh[2];

    tdm_demux8 #(.FREE_RUN(1'b1)) u_fr (
        .Clock(Clock), .Resetn(Resetn), .En(En), .Sync(Sync), .D(D),
        .Q(q0), .Valid(valid0), .Slot(slot0), .Y(y0), .Err(err0)
    );

    tdm_demux8 #(.FREE_RUN(1'b0)) u_nf (
        .Clock(Clock), .Resetn(Resetn), .En(En), .Sync(Sync), .D(D),
        .Q(q1), .Valid(valid1), .Slot(slot1), .Y(y1), .Err(err1)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            pos[m]  = -1;
            bits[m] = 8'h00;
            qh[m]   = 8'h00;
        end
        cyc0.delete(); cyc1.delete(); frm0.delete(); frm1.delete();
    endtask

    task automatic model(input int m, input logic en, input logic sync, input logic d);
        exp_t e;
        e.err   = 1'b0;
        e.valid = 1'b0;
        if (en) begin
            if (sync) begin
                e.err   = (pos[m] > 0);
                bits[m] = 8'h00;
                bits[m][0] = d;
                pos[m]  = 1;
            end else if (pos[m] >= 0) begin
                bits[m][pos[m]] = d;
                pos[m]++;
                if (pos[m] == 8) begin
                    e.valid = 1'b1;
                    qh[m]   = bits[m];
                    if (m == 0) frm0.push_back(bits[m]);
                    else        frm1.push_back(bits[m]);
                    pos[m] = (m == 0) ? 0 : -1;
                end
            end
        end
        e.slot = (pos[m] < 0) ? 3'd0 : 3'(pos[m]);
        e.y    = (pos[m] < 0) ? 8'h00 : (8'h01 << pos[m]);
        e.q    = qh[m];
        if (m == 0) cyc0.push_back(e);
        else        cyc1.push_back(e);
    endtask

    task automatic step(input logic en, input logic sync, input logic d);
        @(negedge Clock);
        En = en; Sync = sync; D = d;
        model(0, en, sync, d);
        model(1, en, sync, d);
    endtask

    task automatic send_frame(input logic [7:0] w);
        for (int i = 0; i < 8; i++) step(1'b1, (i == 0), w[i]);
    endtask

    task automatic send_bits(input logic [7:0] w);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, w[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs();
        check("rst_q0", q0, 8'h00);         check("rst_q1", q1, 8'h00);
        check("rst_slot0", 8'(slot0), 8'h00); check("rst_slot1", 8'(slot1), 8'h00);
        check("rst_y0", y0, 8'h00);         check("rst_y1", y1, 8'h00);
        check("rst_valid", {6'b0, valid0, valid1}, 8'h00);
        check("rst_err", {6'b0, err0, err1}, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge Clock);
        En = 1'b0; Sync = 1'b0;
        Resetn = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge Clock);
        Resetn = 1'b1;
    endtask

    // Monitor: per-cycle outputs plus the completed-frame scoreboard.
    always begin
        exp_t e;
        @(posedge Clock);
        #1;
        if (cyc0.size() > 0) begin
            e = cyc0.pop_front();
            check("slot_fr", 8'(slot0), 8'(e.slot));
            check("y_fr", y0, e.y);
            check("err_fr", 8'(err0), 8'(e.err));
            check("valid_fr", 8'(valid0), 8'(e.valid));
            check("qhold_fr", q0, e.q);
            if (valid0) begin
                if (frm0.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL frame_fr: got Valid with Q=%h, expected no frame", q0);
                end else check("frame_fr", q0, frm0.pop_front());
            end
        end
        if (cyc1.size() > 0) begin
            e = cyc1.pop_front();
            check("slot_nf", 8'(slot1), 8'(e.slot));
            check("y_nf", y1, e.y);
            check("err_nf", 8'(err1), 8'(e.err));
            check("valid_nf", 8'(valid1), 8'(e.valid));
            check("qhold_nf", q1, e.q);
            if (valid1) begin
                if (frm1.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL frame_nf: got Valid with Q=%h, expected no frame", q1);
                end else check("frame_nf", q1, frm1.pop_front());
            end
        end
    end

    initial begin
        model_reset();
        #2;
        check_reset_outputs();
        @(negedge Clock);
        Resetn = 1'b1;

        // Basic frame.
        send_frame(8'hA5);
        idle(2);

        // Back-to-back frames: only the free-running copy takes the second.
        send_frame(8'h3C);
        send_bits(8'hC3);
        idle(2);

        // En gap after slot 4 holds the slot.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i == 0), i[0] ~^ i[1] ? 1'b1 : 1'b0);
            if (i == 4) idle(3);
        end
        idle(1);
        send_frame(8'hA5);
        idle(1);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i == 0), 1'(8'hA5 >> i));
            if (i == 4) idle(3);
        end
        idle(2);

        // Misaligned Sync at slot 5, then realign with 8'h0F.
        for (int i = 0; i < 5; i++) step(1'b1, (i == 0), 1'b0);
        send_frame(8'h0F);
        idle(2);

        // Sync on the slot-7 cycle: error, no completion.
        for (int i = 0; i < 7; i++) step(1'b1, (i == 0), 1'b1);
        send_frame(8'h81);
        idle(2);

        // Framed mode returns to idle; bits without Sync are ignored there.
        send_frame(8'hFF);
        send_bits(8'h12);
        idle(2);

        // Reset mid-frame after Q=8'h5A.
        send_frame(8'h5A);
        for (int i = 0; i < 4; i++) step(1'b1, (i == 0), 1'b1);
        do_reset();
        send_bits(8'h77);
        send_frame(8'h96);
        idle(2);

        // Randomised stream.
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) != 0, ($urandom % 12) == 0, 1'($urandom));
        end
        idle(3);

        tests++;
        if (frm0.size() != 0 || frm1.size() != 0) begin
            fails++;
            $display("FAIL frames_left: got %0d/%0d unconsumed expected 0/0",
                     frm0.size(), frm1.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tdm_demux8.md
Name: tdm_demux8

Overview:
- Receiving end of the 8:1 select-mux path: the mux serialises eight channels onto one wire by stepping its 3-bit select; this block rebuilds the 8-bit word.
- An internal 3-bit slot counter drives a 3-to-8 one-hot decode that write-enables one bit of a staging register per accepted cycle.
- A completed frame is transferred to a holding register, and a one-cycle valid pulse is raised.
- Sits directly after the mux/serial link in lab datapaths.

Parameters:
- FREE_RUN, 1, 1 = after slot 7 wrap to slot 0 and keep capturing without a new Sync; 0 = return to IDLE and wait for Sync each frame.

Ports:
- Clock  input  1  rising-edge clock.
- Resetn  input  1  asynchronous active-low reset.
- En  input  1  a serial bit is present on D this cycle; when low, nothing advances.
- Sync  input  1  marks D as slot 0 of a frame; sampled only when En=1.
- D  input  1  serial data bit for the current slot.
- Q  output  8  last completed frame; bit k = slot k.
- Valid  output  1  one-cycle pulse; Q updated this cycle.
- Slot  output  3  slot index the next accepted bit will occupy.
- Y  output  8  one-hot decode of Slot; all zero in IDLE.
- Err  output  1  one-cycle pulse; Sync seen while Slot != 0 in RUN.

Behaviour:
- Reset (async, Resetn=0): state=IDLE, Slot=0, staging=0, Q=8'h00, Valid=0, Err=0. Y is combinational from state/Slot, so Y=0.
- States: IDLE, RUN.
- IDLE, En=1 & Sync=1:
  - staging[0]<=D, Slot<=1, go RUN.
  - Anything else: hold, no outputs change except Valid/Err dropping to 0.
- RUN, En=0: full hold (Slot, staging, state unchanged).
- RUN, En=1, Sync=0, Slot<7: staging[Slot]<=D, Slot<=Slot+1.
- RUN, En=1, Sync=0, Slot==7:
  - Q<={D, staging[6:0]} and Valid<=1 on the same edge. Latency: Q/Valid are visible the cycle after bit 7 is accepted.
  - Slot<=0 (mod-8 wrap).
  - Stay in RUN if FREE_RUN=1, else go IDLE.
  - staging is not cleared.
- RUN, En=1, Sync=1, Slot==0 (aligned frame start): normal slot-0 capture, no error.
- RUN, En=1, Sync=1, Slot!=0 (misaligned):
  - Err<=1; the partial frame is discarded (Q untouched, no Valid).
  - staging[0]<=D, Slot<=1; realign and stay in RUN.
- Sync on the slot-7 cycle counts as misaligned: Err pulses, the frame does NOT complete, D becomes slot 0.
- Valid and Err are registered single-cycle pulses; they are 0 on every cycle without a qualifying event.
  - Back-to-back frames in FREE_RUN with En held high give Valid exactly every 8 cycles.
- Y = one-hot(Slot) while in RUN (1 << Slot); 8'h00 in IDLE. Exactly one bit is high in RUN.
- Reset asserted mid-frame: immediate return to IDLE; partial frame lost; Q cleared to 0.
- Q holds its value indefinitely between Valid pulses; En gaps inside a frame do not corrupt it.

Test Plan:
- Reset, then 8 cycles En=1 with Sync on the first cycle, D = bits of 8'hA5 LSB first -> Valid=1 one cycle after the 8th bit, Q=8'hA5, Slot=0, Err=0.
- FREE_RUN=1: Sync once, then 16 bits giving 8'h3C then 8'hC3 with En continuous -> two Valid pulses 8 cycles apart, Q=8'h3C then 8'hC3.
- Same 8'hA5 frame with En deasserted for 3 cycles after slot 4 -> Slot holds at 5, Y holds 8'b0010_0000, final Q=8'hA5 with Valid delayed by 3 cycles.
- Sync at Slot=5 mid-frame -> Err pulses one cycle, no Valid, Slot=1. The following 7 bits of 8'h0F (with the Sync bit as bit 0) -> Q=8'h0F.
- FREE_RUN=0: complete frame 8'hFF, then 8 more En=1 bits without Sync -> one Valid only, state IDLE, Y=0, Q stays 8'hFF.
- Resetn pulsed low at Slot=4 after a previous Q=8'h5A -> Q=0, Slot=0, Y=0 asynchronously; no Valid until the next Sync frame.
